// File: rtl/hilo_control.sv
// HI/LO register control for the mul/div unit: tracks an in-flight op,
// commits its result, services MTHI/MTLO/MFHI/MFLO and stalls the pipeline.
module hilo_control (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic        is_mthi,
  input  logic        is_mtlo,
  input  logic        is_mfhi,
  input  logic        is_mflo,
  input  logic [31:0] wdata,
  input  logic        muldiv_wait,
  input  logic [31:0] muldiv_hi,
  input  logic [31:0] muldiv_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        clear_muldiv
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] hi_next;
  logic [31:0] lo_next;
  logic        commit;
  logic        hilo_access;

  assign commit      = (state == BUSY) && !muldiv_wait;
  assign hilo_access = start | is_mthi | is_mtlo | is_mfhi | is_mflo;

  // Output decode: stall only while a result is still pending and someone
  // needs HI/LO; reads bypass the unit's result during the commit cycle.
  always_comb begin
    stall        = 1'b0;
    rdata        = 32'd0;
    clear_muldiv = reset | flush;
    if (!reset && !flush && (state == BUSY) && muldiv_wait && hilo_access) begin
      stall = 1'b1;
    end
    if (!reset) begin
      if (is_mfhi) begin
        rdata = commit ? muldiv_hi : hi;
      end else if (is_mflo) begin
        rdata = commit ? muldiv_lo : lo;
      end
    end
  end

  // Next-state and next HI/LO: start wins over MT* in IDLE, MT* overrides
  // the committed value per register, and flush cancels everything.
  always_comb begin
    state_next = state;
    hi_next    = hi;
    lo_next    = lo;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = BUSY;
        end else if (!stall) begin
          if (is_mthi) hi_next = wdata;
          if (is_mtlo) lo_next = wdata;
        end
      end
      BUSY: begin
        if (!muldiv_wait) begin
          hi_next    = is_mthi ? wdata : muldiv_hi;
          lo_next    = is_mtlo ? wdata : muldiv_lo;
          state_next = start ? BUSY : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
      hi_next    = hi;
      lo_next    = lo;
    end
  end

  // State and architectural HI/LO registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_next;
      hi    <= hi_next;
      lo    <= lo_next;
    end
  end

endmodule

// File: tb/tb_hilo_control.sv
// Self-checking bench for hilo_control: directed scenarios plus a random
// run checked against a transaction-level model of HI/LO behaviour.
module tb_hilo_control;

  logic        clk;
  logic        reset;
  logic        start;
  logic        flush;
  logic        is_mthi;
  logic        is_mtlo;
  logic        is_mfhi;
  logic        is_mflo;
  logic [31:0] wdata;
  logic        muldiv_wait;
  logic [31:0] muldiv_hi;
  logic [31:0] muldiv_lo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;
  logic        stall;
  logic        clear_muldiv;

  int checks = 0;
  int errors = 0;

  // Model: is an op outstanding, and the architectural HI/LO values.
  bit          m_pending;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  hilo_control dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .is_mthi(is_mthi), .is_mtlo(is_mtlo), .is_mfhi(is_mfhi), .is_mflo(is_mflo),
    .wdata(wdata), .muldiv_wait(muldiv_wait), .muldiv_hi(muldiv_hi),
    .muldiv_lo(muldiv_lo), .hi(hi), .lo(lo), .rdata(rdata), .stall(stall),
    .clear_muldiv(clear_muldiv)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic exp_stall();
    if (reset || flush) return 1'b0;
    return m_pending && muldiv_wait && (start || is_mthi || is_mtlo || is_mfhi || is_mflo);
  endfunction

  function automatic logic [31:0] exp_rdata();
    bit result_ready;
    result_ready = m_pending && !muldiv_wait;
    if (reset) return 32'd0;
    if (is_mfhi) return result_ready ? muldiv_hi : m_hi;
    if (is_mflo) return result_ready ? muldiv_lo : m_lo;
    return 32'd0;
  endfunction

  // Apply one clock of the architectural rules to the model.
  task automatic model_update();
    if (reset) begin
      m_pending = 0;
      m_hi = 32'd0;
      m_lo = 32'd0;
    end else if (flush) begin
      m_pending = 0;
    end else if (!m_pending) begin
      if (start) m_pending = 1;
      else begin
        if (is_mthi) m_hi = wdata;
        if (is_mtlo) m_lo = wdata;
      end
    end else if (!muldiv_wait) begin
      m_hi = is_mthi ? wdata : muldiv_hi;
      m_lo = is_mtlo ? wdata : muldiv_lo;
      m_pending = start;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic f,
                               input logic mthi, input logic mtlo,
                               input logic mfhi, input logic mflo,
                               input logic [31:0] wd, input logic w,
                               input logic [31:0] mh, input logic [31:0] ml);
    reset = r; start = s; flush = f;
    is_mthi = mthi; is_mtlo = mtlo; is_mfhi = mfhi; is_mflo = mflo;
    wdata = wd; muldiv_wait = w; muldiv_hi = mh; muldiv_lo = ml;
    #1;
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'd0, 1'b1, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    applyStimulus(1, 1, 1, 1, 1, 1, 0, 32'hFFFF_FFFF, 1'b0, 32'h1, 32'h2);
    tick();
    tick();
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_hilo hi=%h lo=%h expected 0/0", hi, lo);
    end
    checks++;
    if (stall !== 1'b0 || clear_muldiv !== 1'b1 || rdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs stall=%b clear=%b rdata=%h expected 0/1/0", stall, clear_muldiv, rdata);
    end
  endtask

  task automatic test_mthi();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 32'h1234_5678, 1'b1, 32'd0, 32'd0);
    checks++;
    if (clear_muldiv !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_idle clear=%b expected 0", clear_muldiv);
    end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'd0, 1'b1, 32'd0, 32'd0);
    checks++;
    if (hi !== 32'h1234_5678 || rdata !== 32'h1234_5678 || stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mthi_mfhi hi=%h rdata=%h stall=%b expected 12345678/12345678/0", hi, rdata, stall);
    end
    tick();
  endtask

  task automatic test_muldiv();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 32'd0, 1'b1, 32'd0, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'd0, 1'b1, 32'hA, 32'hB);
      checks++;
      if (stall !== 1'b1) begin
        errors++;
        $display("[TB] FAIL wait_stall cycle=%0d stall=%b expected 1", i, stall);
      end
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'd0, 1'b0, 32'hA, 32'hB);
    checks++;
    if (stall !== 1'b0 || rdata !== 32'hB) begin
      errors++;
      $display("[TB] FAIL commit_bypass stall=%b rdata=%h expected 0/0000000b", stall, rdata);
    end
    tick();
    idle_inputs();
    checks++;
    if (hi !== 32'hA || lo !== 32'hB) begin
      errors++;
      $display("[TB] FAIL commit_hilo hi=%h lo=%h expected a/b", hi, lo);
    end
  endtask

  task automatic test_flush();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 32'd0, 1'b1, 32'd0, 32'd0);
    tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 32'd0, 1'b1, 32'h55, 32'h66);
    checks++;
    if (clear_muldiv !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_outputs clear=%b stall=%b expected 1/0", clear_muldiv, stall);
    end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'd0, 1'b0, 32'h77, 32'h88);
    tick();
    idle_inputs();
    checks++;
    if (hi !== 32'hA || lo !== 32'hB) begin
      errors++;
      $display("[TB] FAIL flush_hilo hi=%h lo=%h expected a/b", hi, lo);
    end
  endtask

  task automatic test_commit_mt();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 32'd0, 1'b1, 32'd0, 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h5, 1'b0, 32'h7, 32'h9);
    tick();
    idle_inputs();
    checks++;
    if (hi !== 32'h7 || lo !== 32'h5) begin
      errors++;
      $display("[TB] FAIL commit_mtlo hi=%h lo=%h expected 7/5", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 32'd0, 1'b1, 32'd0, 32'd0);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 32'd0, 1'b0, 32'h11, 32'h22);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'd0, 1'b1, 32'h0, 32'h0);
    checks++;
    if (hi !== 32'h11 || lo !== 32'h22 || stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_first hi=%h lo=%h stall=%b expected 11/22/1", hi, lo, stall);
    end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'd0, 1'b0, 32'h33, 32'h44);
    tick();
    idle_inputs();
    checks++;
    if (hi !== 32'h33 || lo !== 32'h44) begin
      errors++;
      $display("[TB] FAIL b2b_second hi=%h lo=%h expected 33/44", hi, lo);
    end
  endtask

  task automatic test_reset_busy();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 32'd0, 1'b1, 32'd0, 32'd0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 32'd0, 1'b1, 32'd0, 32'd0);
    checks++;
    if (stall !== 1'b0 || clear_muldiv !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_busy_out stall=%b clear=%b expected 0/1", stall, clear_muldiv);
    end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'd0, 1'b0, 32'hDEAD, 32'hBEEF);
    tick();
    idle_inputs();
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_busy_hilo hi=%h lo=%h expected 0/0", hi, lo);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 2000; n++) begin
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 2) == 0), $urandom(),
                    ($urandom_range(0, 2) != 0), $urandom(), $urandom());
      checks++;
      if (stall !== exp_stall() || rdata !== exp_rdata() || clear_muldiv !== (reset | flush)) begin
        errors++;
        $display("[TB] FAIL rand_comb n=%0d stall=%b/%b rdata=%h/%h clear=%b/%b",
                 n, stall, exp_stall(), rdata, exp_rdata(), clear_muldiv, reset | flush);
      end
      tick();
      checks++;
      if (hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("[TB] FAIL rand_hilo n=%0d hi=%h/%h lo=%h/%h", n, hi, m_hi, lo, m_lo);
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    m_pending = 0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_mthi();
    test_muldiv();
    test_flush();
    test_commit_mt();
    test_back_to_back();
    test_reset_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_control.md
HILO_CONTROL -- requirements
Module: hilo_control

Interface
REQ-001 The module SHALL use one clock and one reset: reset is synchronous and active-high, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  execute stage issues a mul/div op this cycle.
REQ-005 flush  input  1  kill any in-flight mul/div op; discard its result.
REQ-006 is_mthi, is_mtlo  input  1 each  write wdata to HI / LO.
REQ-007 is_mfhi, is_mflo  input  1 each  read HI / LO onto rdata.
REQ-008 wdata  input  32  source operand for MTHI/MTLO.
REQ-009 muldiv_wait  input  1  wait_result from the mul/div unit.
REQ-010 muldiv_hi, muldiv_lo  input  32  result from the mul/div unit.
REQ-011 hi, lo  output  32  architectural HI/LO registers; these feed the unit's hi_in/lo_in.
REQ-012 rdata  output  32  MFHI/MFLO read data (combinational).
REQ-013 stall  output  1  freeze the pipeline (combinational).
REQ-014 clear_muldiv  output  1  drives the unit's clear input.

Function
REQ-015 State machine states SHALL be IDLE and BUSY, one register.
REQ-016 IDLE with start=1 and flush=0 SHALL go to BUSY at the next edge; otherwise IDLE SHALL stay IDLE.
REQ-017 In BUSY, the first cycle with muldiv_wait=0 is the commit cycle.
REQ-018 Commit cycle: at the edge, hi<=muldiv_hi, lo<=muldiv_lo, state<=IDLE.
REQ-019 In BUSY with muldiv_wait=1, state, hi and lo SHALL hold.
REQ-020 Minimum latency SHALL be: start at cycle N, commit at the end of cycle N+1, with new hi/lo visible in cycle N+2.
REQ-021 stall SHALL be 1 when state=BUSY, muldiv_wait=1, and any of start/is_mthi/is_mtlo/is_mfhi/is_mflo is 1.
REQ-022 stall SHALL be 0 in IDLE and in the commit cycle.
REQ-023 Commit-cycle bypass: is_mfhi gives rdata=muldiv_hi; is_mflo gives rdata=muldiv_lo.
REQ-024 Outside the commit cycle: is_mfhi gives rdata=hi; is_mflo gives rdata=lo.
REQ-025 If is_mfhi=is_mflo=1, HI SHALL take priority; if neither is set, rdata=0.
REQ-026 MTHI/MTLO SHALL write at the edge only when stall=0 and flush=0.
REQ-027 is_mthi and is_mtlo both set SHALL write both registers.
REQ-028 MT* in the commit cycle SHALL override the committed value for that register only; the other register takes the commit value.
REQ-029 start with MT* in the same IDLE cycle: start SHALL be accepted and MT* SHALL be ignored.
REQ-030 start in the commit cycle SHALL be accepted: the commit happens and state stays BUSY for the new op.
REQ-031 flush=1 SHALL force state<=IDLE and suppress all hi/lo writes that edge, including a commit.
REQ-032 clear_muldiv SHALL be 1 in any cycle with flush=1 or reset=1, and 0 otherwise.
REQ-033 stall SHALL be 0 whenever flush=1.

Reset
REQ-034 reset=1 at an edge SHALL set state=IDLE, hi=0, lo=0.
REQ-035 reset mid-operation SHALL discard the pending result; no commit occurs.
REQ-036 reset SHALL take priority over flush, start and MT*.
REQ-037 During reset, stall=0, rdata follows the reset values, and clear_muldiv=1.

Verification
REQ-038 Reset then MTHI wdata=0x1234_5678, then MFHI -> hi=0x1234_5678, rdata=0x1234_5678, stall=0.
REQ-039 start, muldiv_wait=1 for 3 cycles, then 0 with muldiv_hi=0xA, muldiv_lo=0xB -> stall=1 on MFLO during the wait, stall=0 with rdata=0xB in the commit cycle, then hi=0xA, lo=0xB.
REQ-040 start then flush in cycle N+1 while muldiv_wait=1 -> clear_muldiv=1, state IDLE, hi/lo unchanged.
REQ-041 Commit cycle with is_mtlo=1, wdata=0x5, muldiv_lo=0x9, muldiv_hi=0x7 -> lo=0x5, hi=0x7.
REQ-042 start in the commit cycle of an op -> first result committed, state stays BUSY, the second result commits later.
REQ-043 reset asserted while BUSY -> hi=lo=0, state IDLE, the later muldiv_wait=0 does not write.
